icache_sram_1r1w_bypass: RTL and testbench
==========================================

// Module: icache_sram_1r1w_bypass
// PURPOSE
//  Synthesizable, parametrised 1-read/1-write SRAM for the instruction cache tag/data arrays.
//  Successor of the fixed 16x8 2-bit-lane macro model:
//   - width, depth, lane width and read latency are parameters
//   - a write and a read to the same address in the same cycle return the merged new data (write-first)
//   - a post-reset clear sequencer zeroes every word before the array accepts traffic
//  Sits between the icache controller and the tag/data storage; one clock domain.
// PARAMETERS
//  DATA_WIDTH    8  bits per word
//  ADDR_WIDTH    4  address bits; RAM_DEPTH = 1<<ADDR_WIDTH (localparam)
//  WMASK_GRAN    2  bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_GRAN (localparam)
//  READ_LATENCY  1  1 or 2 cycles from read request to dout_r/rd_valid
//  CLEAR_ON_RST  1  1: run zero-clear after reset; 0: go straight to READY (array contents X)
// PORTS
//  clk       in   1             single clock, all logic on posedge
//  rst       in   1             asynchronous, active-high reset
//  csb_w     in   1             active-low write enable
//  addr_w    in   ADDR_WIDTH    write address
//  wmask_w   in   NUM_WMASKS    lane i writes din_w[i*WMASK_GRAN +: WMASK_GRAN]
//  din_w     in   DATA_WIDTH    write data
//  csb_r     in   1             active-low read enable
//  addr_r    in   ADDR_WIDTH    read address
//  dout_r    out  DATA_WIDTH    read data; holds last value while rd_valid=0
//  rd_valid  out  1             one-cycle pulse, dout_r valid this cycle
//  busy      out  1             high during clear; requests are dropped while high
// BEHAVIOUR
//  Reset (async assert, sync release): dout_r=0, rd_valid=0, read pipeline flushed, clear counter=0.
//    busy=1 if CLEAR_ON_RST, else 0. Array contents not reset by rst itself.
//  FSM states:
//    CLEAR: each cycle write 0 to mem[cnt], cnt++. At cnt==RAM_DEPTH-1, write it, then go READY next cycle.
//           busy=1 for exactly RAM_DEPTH cycles after reset release.
//    READY: busy=0, serve traffic. No exit except rst.
//  Reset mid-clear or mid-read: everything restarts; in-flight reads discarded (no rd_valid).
//  Write (READY, csb_w=0): at posedge, mem[addr_w] lanes with wmask_w=1 take din_w; others unchanged.
//    wmask_w=0 is a legal no-op.
//  Read (READY, csb_r=0) sampled at posedge T:
//    LAT=1: dout_r/rd_valid at T+1.
//    LAT=2: array data captured at T+1, presented at T+2.
//    Back-to-back reads every cycle are supported at both latencies.
//  Collision (csb_w=0, csb_r=0, addr_w==addr_r, same edge): read returns, per lane,
//    din_w where wmask_w=1, else old mem.
//  A write on any later edge never alters data already captured for an earlier read.
//  Requests during busy=1: ignored, no rd_valid, no array change.
//  Elaboration checks ($fatal): DATA_WIDTH%WMASK_GRAN!=0, READ_LATENCY not in {1,2}, ADDR_WIDTH<1.
// STRUCTURE
//  Package icache_sram_pkg:
//    enum sram_state_e {S_CLEAR, S_READY}
//    function lane_merge(old, new, mask, gran): used by both the write path and the bypass.
//  Sub-module icache_sram_clear_ctrl: FSM + ADDR_WIDTH counter; outputs busy, clr_we, clr_addr.
//    Top muxes the clear write over the user write port.
//  Array: reg [DATA_WIDTH-1:0] mem [RAM_DEPTH]; read pipeline generated by READ_LATENCY.
// TESTING
//  1 Reset, CLEAR_ON_RST=1, 16x8 -> busy high exactly 16 cycles; then read all 16 addrs -> 8'h00, rd_valid per read.
//  2 Write addr 3 din 8'hA5 mask 4'b1111, then addr 3 din 8'hFF mask 4'b0101 -> read addr 3 = 8'hB7.
//  3 mem[5]=8'h00; same-cycle write addr 5 din 8'hFF mask 4'b1100 + read addr 5 -> dout_r=8'hF0 (LAT 1 and 2).
//  4 LAT=2: read addr 7 (=8'h11) at T, write addr 7 =8'h22 at T+1 -> dout_r=8'h11 at T+2, next read returns 8'h22.
//  5 Assert rst at clear cycle 6 and during a LAT=2 read -> no rd_valid; busy restarts for full 16 cycles.
//  6 Reads/writes issued while busy=1 -> no rd_valid; after clear, target addrs still read 8'h00.

Source files
------------

// File: rtl/icache_sram_pkg.sv
// Shared types and the lane-merge helper for the icache 1R1W SRAM.
// lane_merge serves both the array write path and the same-address read bypass.
package icache_sram_pkg;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } sram_state_e;

  // Widest word the merge helper handles; callers zero-extend into it and truncate back.
  localparam int unsigned LANE_MERGE_W   = 256;
  localparam int unsigned LANE_MERGE_IDX = 8;

  typedef logic [LANE_MERGE_W-1:0] lane_vec_t;

  function automatic lane_vec_t lane_merge(input lane_vec_t   old_data,
                                           input lane_vec_t   new_data,
                                           input lane_vec_t   mask,
                                           input int unsigned gran);
    lane_vec_t                 res;
    logic [LANE_MERGE_IDX-1:0] bit_idx;
    logic [LANE_MERGE_IDX-1:0] lane_idx;
    res = old_data;
    for (int b = 0; b < LANE_MERGE_W; b++) begin
      bit_idx  = LANE_MERGE_IDX'(b);
      lane_idx = LANE_MERGE_IDX'(b / int'(gran));
      if (mask[lane_idx]) begin
        res[bit_idx] = new_data[bit_idx];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/icache_sram_1r1w_bypass_if.sv
// Request/response bundle between the icache controller (master) and the SRAM (slave).
interface icache_sram_1r1w_bypass_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WMASK_GRAN = 2
);
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;

  logic                  csb_w;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [NUM_WMASKS-1:0] wmask_w;
  logic [DATA_WIDTH-1:0] din_w;
  logic                  csb_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  rd_valid;
  logic                  busy;

  modport master (
    output csb_w, addr_w, wmask_w, din_w, csb_r, addr_r,
    input  dout_r, rd_valid, busy
  );

  modport slave (
    input  csb_w, addr_w, wmask_w, din_w, csb_r, addr_r,
    output dout_r, rd_valid, busy
  );

endinterface

// File: rtl/icache_sram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once writing zero, then parks in READY.
module icache_sram_clear_ctrl
  import icache_sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam sram_state_e RstState = CLEAR_ON_RST ? S_CLEAR : S_READY;

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RstState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      S_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (&cnt_q) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: state_d = RstState;
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/icache_sram_1r1w_bypass.sv
// Parametrised 1R1W icache SRAM with write-first same-address bypass, masked lanes,
// configurable read latency and an optional zero-clear pass after reset.
module icache_sram_1r1w_bypass
  import icache_sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned WMASK_GRAN   = 2,
  parameter int unsigned READ_LATENCY = 1,
  parameter bit          CLEAR_ON_RST = 1'b1
) (
  input logic                       clk,
  input logic                       rst,
  icache_sram_1r1w_bypass_if.slave  bus
);

  localparam int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / WMASK_GRAN;

  typedef logic [DATA_WIDTH-1:0] word_t;

  if (WMASK_GRAN == 0 || (DATA_WIDTH % WMASK_GRAN) != 0) begin : g_bad_gran
    $fatal(1, "DATA_WIDTH must be a multiple of WMASK_GRAN");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end
  if (ADDR_WIDTH < 1) begin : g_bad_addr
    $fatal(1, "ADDR_WIDTH must be at least 1");
  end
  if (DATA_WIDTH > LANE_MERGE_W) begin : g_bad_width
    $fatal(1, "DATA_WIDTH exceeds lane_merge capacity");
  end

  function automatic word_t merge_word(input word_t old_w, input word_t new_w,
                                       input logic [NUM_WMASKS-1:0] m);
    return word_t'(lane_merge(lane_vec_t'(old_w), lane_vec_t'(new_w), lane_vec_t'(m),
                              WMASK_GRAN));
  endfunction

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  icache_sram_clear_ctrl #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear_ctrl (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  word_t mem [RAM_DEPTH];

  // The clear sequencer owns the write port while busy; user requests are dropped.
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  word_t                 wdata;
  logic [NUM_WMASKS-1:0] wmask;

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    wmask = '0;
    if (busy) begin
      we    = clr_we;
      waddr = clr_addr;
      wmask = '1;
    end else begin
      we    = ~bus.csb_w;
      waddr = bus.addr_w;
      wdata = bus.din_w;
      wmask = bus.wmask_w;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= merge_word(mem[waddr], wdata, wmask);
    end
  end

  logic  rd_req;
  logic  hit;
  word_t rd_word;

  assign rd_req  = ~busy & ~bus.csb_r;
  assign hit     = ~bus.csb_w & (bus.addr_w == bus.addr_r);
  assign rd_word = hit ? merge_word(mem[bus.addr_r], bus.din_w, bus.wmask_w)
                       : mem[bus.addr_r];

  word_t dout_q;
  logic  valid_q;

  // Read data is snapshotted at the request edge, so later writes cannot disturb it.
  if (READ_LATENCY == 2) begin : g_lat2
    logic  s1_valid_q;
    word_t s1_data_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
        valid_q    <= 1'b0;
        dout_q     <= '0;
      end else begin
        s1_valid_q <= rd_req;
        if (rd_req) begin
          s1_data_q <= rd_word;
        end
        valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          dout_q <= s1_data_q;
        end
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        dout_q  <= '0;
      end else begin
        valid_q <= rd_req;
        if (rd_req) begin
          dout_q <= rd_word;
        end
      end
    end
  end

  assign bus.dout_r   = dout_q;
  assign bus.rd_valid = valid_q;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_icache_sram_1r1w_bypass.sv
// Directed bench: one latency-1 and one latency-2 instance driven with identical stimulus.
module tb_icache_sram_1r1w_bypass;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   n;
  logic seen_v;

  always #5 clk = ~clk;

  icache_sram_1r1w_bypass_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WMASK_GRAN(2)) a0 ();
  icache_sram_1r1w_bypass_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WMASK_GRAN(2)) a1 ();

  icache_sram_1r1w_bypass #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .WMASK_GRAN(2), .READ_LATENCY(1), .CLEAR_ON_RST(1'b1)
  ) u_lat1 (
    .clk (clk),
    .rst (rst),
    .bus (a0)
  );

  icache_sram_1r1w_bypass #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .WMASK_GRAN(2), .READ_LATENCY(2), .CLEAR_ON_RST(1'b1)
  ) u_lat2 (
    .clk (clk),
    .rst (rst),
    .bus (a1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a0.csb_w = 1'b1; a0.csb_r = 1'b1;
    a1.csb_w = 1'b1; a1.csb_r = 1'b1;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [7:0] d, input logic [3:0] m);
    a0.csb_w = 1'b0; a0.addr_w = a; a0.din_w = d; a0.wmask_w = m;
    a1.csb_w = 1'b0; a1.addr_w = a; a1.din_w = d; a1.wmask_w = m;
  endtask

  task automatic set_rd(input logic [3:0] a);
    a0.csb_r = 1'b0; a0.addr_r = a;
    a1.csb_r = 1'b0; a1.addr_r = a;
  endtask

  initial begin
    idle();
    set_wr(4'd0, 8'h00, 4'h0);
    set_rd(4'd0);
    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst_busy_l1", 8'(a0.busy), 8'd1);
    chk("rst_busy_l2", 8'(a1.busy), 8'd1);
    chk("rst_valid_l1", 8'(a0.rd_valid), 8'd0);
    chk("rst_dout_l2", a1.dout_r, 8'h00);

    // Clear pass, with a write+read to the same address offered on every busy edge.
    rst    = 1'b0;
    n      = 0;
    seen_v = 1'b0;
    while (a0.busy === 1'b1 && n < 40) begin
      set_wr(4'(n), 8'hFF, 4'hF);
      set_rd(4'(n));
      step();
      n++;
      seen_v = seen_v | a0.rd_valid | a1.rd_valid;
    end
    idle();
    chk("clear_cycles", 8'(n), 8'd16);
    chk("clear_busy_l2", 8'(a1.busy), 8'd0);
    chk("busy_no_valid", 8'(seen_v), 8'd0);

    // Back-to-back reads of the whole array.
    for (int i = 0; i < 16; i++) begin
      set_rd(4'(i));
      step();
      chk("clr_valid_l1", 8'(a0.rd_valid), 8'd1);
      chk("clr_dout_l1", a0.dout_r, 8'h00);
      chk("clr_valid_l2", 8'(a1.rd_valid), (i > 0) ? 8'd1 : 8'd0);
      if (i > 0) chk("clr_dout_l2", a1.dout_r, 8'h00);
    end
    idle();
    step();
    chk("clr_last_valid_l2", 8'(a1.rd_valid), 8'd1);
    chk("clr_last_dout_l2", a1.dout_r, 8'h00);
    chk("clr_idle_valid_l1", 8'(a0.rd_valid), 8'd0);

    // Masked partial write.
    set_wr(4'd3, 8'hA5, 4'b1111);
    step();
    set_wr(4'd3, 8'hFF, 4'b0101);
    step();
    idle();
    set_rd(4'd3);
    step();
    idle();
    chk("mask_valid_l1", 8'(a0.rd_valid), 8'd1);
    chk("mask_dout_l1", a0.dout_r, 8'hB7);
    step();
    chk("mask_valid_l2", 8'(a1.rd_valid), 8'd1);
    chk("mask_dout_l2", a1.dout_r, 8'hB7);
    chk("hold_valid_l1", 8'(a0.rd_valid), 8'd0);
    chk("hold_dout_l1", a0.dout_r, 8'hB7);

    // Same-edge write and read of one address: write-first per lane.
    set_wr(4'd5, 8'hFF, 4'b1100);
    set_rd(4'd5);
    step();
    idle();
    chk("byp_dout_l1", a0.dout_r, 8'hF0);
    step();
    chk("byp_valid_l2", 8'(a1.rd_valid), 8'd1);
    chk("byp_dout_l2", a1.dout_r, 8'hF0);
    set_rd(4'd5);
    step();
    idle();
    chk("byp_stored_l1", a0.dout_r, 8'hF0);
    step();
    chk("byp_stored_l2", a1.dout_r, 8'hF0);

    // Write one edge after a read must not alter the captured data.
    set_wr(4'd7, 8'h11, 4'hF);
    step();
    idle();
    set_rd(4'd7);
    step();
    idle();
    chk("late_wr_dout_l1", a0.dout_r, 8'h11);
    set_wr(4'd7, 8'h22, 4'hF);
    step();
    idle();
    chk("late_wr_valid_l2", 8'(a1.rd_valid), 8'd1);
    chk("late_wr_dout_l2", a1.dout_r, 8'h11);
    set_rd(4'd7);
    step();
    idle();
    chk("late_wr_new_l1", a0.dout_r, 8'h22);
    step();
    chk("late_wr_new_l2", a1.dout_r, 8'h22);

    // Reset during an in-flight latency-2 read, then again mid-clear.
    set_rd(4'd2);
    step();
    idle();
    rst = 1'b1;
    #1;
    chk("midrd_busy_l2", 8'(a1.busy), 8'd1);
    chk("midrd_valid_l2", 8'(a1.rd_valid), 8'd0);
    chk("midrd_dout_l1", a0.dout_r, 8'h00);
    chk("midrd_dout_l2", a1.dout_r, 8'h00);
    step();
    chk("midrd_flush_l2", 8'(a1.rd_valid), 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("midclr_busy", 8'(a0.busy), 8'd1);
    rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    n   = 0;
    while (a0.busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("reclear_cycles", 8'(n), 8'd16);
    chk("reclear_busy_l2", 8'(a1.busy), 8'd0);

    set_rd(4'd3);
    step();
    set_rd(4'd7);
    chk("reclear_a3_l1", a0.dout_r, 8'h00);
    step();
    idle();
    chk("reclear_a7_l1", a0.dout_r, 8'h00);
    chk("reclear_a3_l2", a1.dout_r, 8'h00);
    step();
    chk("reclear_a7_l2", a1.dout_r, 8'h00);
    chk("reclear_valid_l2", 8'(a1.rd_valid), 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
